// File: rtl/pipelined_nway_mux.sv
// Registered N-way selector with per-channel valid/ready, explicit or round-robin grant.
// Optional accepted-beat counter is enabled by defining PIPE_MUX_XFER_COUNT_EN.
module pipelined_nway_mux #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan,
  output logic [15:0]               xfer_cnt
);

  logic [WIDTH-1:0] w_ch [CHANNELS];
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic [SEL_W-1:0] r_chan_p1;
  logic [SEL_W-1:0] r_rr_ptr;
  logic             w_load_en;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt;
  logic             w_xfer;
  logic [SEL_W-1:0] w_rr_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_ch[i]     = in_data[i*WIDTH +: WIDTH];
    assign in_ready[i] = w_xfer && (w_gnt == SEL_W'(i));
  end

  // Register can take a new beat when empty or being drained this cycle
  assign w_load_en = !r_vld_p1 || out_ready;

  always_comb begin : p_grant
    logic [SEL_W-1:0] idx;
    idx       = '0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (!mode) begin
      if ((int'(sel) < CHANNELS) && in_valid[sel]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = sel;
      end
    end else begin
      // First requester at or after the pointer, wrapping around
      for (int k = 0; k < CHANNELS; k++) begin
        idx = SEL_W'((int'(r_rr_ptr) + k) % CHANNELS);
        if (!w_gnt_vld && in_valid[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = idx;
        end
      end
    end
  end

  assign w_xfer    = !rst && w_load_en && w_gnt_vld;
  assign w_rr_next = (int'(w_gnt) == CHANNELS - 1) ? '0 : w_gnt + 1'b1;

  // Stage p1: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_chan_p1 <= '0;
      r_rr_ptr  <= '0;
    end else if (w_load_en) begin
      r_vld_p1 <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_data_p1 <= w_ch[w_gnt];
        r_chan_p1 <= w_gnt;
        if (mode) r_rr_ptr <= w_rr_next;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_chan  = r_chan_p1;

`ifdef PIPE_MUX_XFER_COUNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_xfer_cnt <= '0;
    else if (r_vld_p1 && out_ready) r_xfer_cnt <= r_xfer_cnt + 16'd1;
  end

  assign xfer_cnt = r_xfer_cnt;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipelined_nway_mux.sv
// Randomized bench for pipelined_nway_mux against a cycle-level behavioural model.
module tb_pipelined_nway_mux;
  localparam int W = 16;
  localparam int C = 4;
  localparam int SW = $clog2(C);

  logic            clk = 1'b0;
  logic            rst;
  logic [C*W-1:0]  in_data;
  logic [C-1:0]    in_valid;
  logic [C-1:0]    in_ready;
  logic [SW-1:0]   sel;
  logic            mode;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_chan;
  logic [15:0]     xfer_cnt;

  pipelined_nway_mux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  bit        m_vld  = 0;
  bit [W-1:0] m_data = '0;
  int        m_chan = 0;
  int        m_rr   = 0;
  bit [15:0] m_cnt  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit [W-1:0] chan_data(input int i);
    return W'(in_data >> (i * W));
  endfunction

  // Which channel wins this cycle, from the selection rules
  function automatic void pick(output bit gv, output int g);
    gv = 0;
    g  = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < C && in_valid[sel]) begin
        gv = 1;
        g  = int'(sel);
      end
    end else begin
      for (int k = 0; k < C; k++) begin
        int c;
        c = (m_rr + k) % C;
        if (!gv && in_valid[c]) begin
          gv = 1;
          g  = c;
        end
      end
    end
  endfunction

  task automatic step();
    bit gv;
    int g;
    bit load;
    logic [C-1:0] er;
    #1;
    pick(gv, g);
    load = !m_vld || out_ready;
    er = '0;
    if (!rst && load && gv) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_data = '0; m_chan = 0; m_rr = 0; m_cnt = '0;
    end else begin
      if (m_vld && out_ready) m_cnt = m_cnt + 16'd1;
      if (load) begin
        if (gv) begin
          m_vld  = 1;
          m_data = chan_data(g);
          m_chan = g;
          if (mode) m_rr = (g + 1) % C;
        end else begin
          m_vld = 0;
        end
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
    chk("out_data", 32'(out_data), 32'(m_data));
`ifdef PIPE_MUX_XFER_COUNT_EN
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`else
    chk("xfer_cnt", 32'(xfer_cnt), 32'h0);
`endif
  endtask

  task automatic rand_data();
    for (int i = 0; i < C; i++) in_data[i*W +: W] = W'($urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = '1; sel = '0; mode = 1'b0; out_ready = 1'b1;
    rand_data();
    @(negedge clk);
    repeat (3) step();
    chk("rst_out_data", 32'(out_data), 32'h0);

    // Release: first beat one cycle later
    rst = 1'b0; mode = 1'b0; sel = 2'd2;
    rand_data();
    in_data[2*W +: W] = 16'hBEEF;
    #1;
    chk("sel2_in_ready", 32'(in_ready), 32'b0100);
    step();
    chk("sel2_data", 32'(out_data), 32'hBEEF);
    chk("sel2_chan", 32'(out_chan), 32'd2);

    // Round-robin over all four channels
    mode = 1'b1; in_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step();
      chk("rr_seq", 32'(out_chan), 32'(i % C));
    end
    in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
      chk("rr_only3", 32'(out_chan), 32'd3);
    end

    // Back-pressure with changing inputs
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      in_valid = C'($urandom);
      mode = 1'($urandom);
      step();
    end
    out_ready = 1'b1; in_valid = '1; mode = 1'b0; sel = 2'd1;
    rand_data();
    step();
    chk("bp_reload_chan", 32'(out_chan), 32'd1);

    // Wrap: push pointer to 3, then only ch0 and ch3 valid
    mode = 1'b1; in_valid = 4'b0100;
    rand_data(); step();
    in_valid = 4'b1001;
    rand_data(); step();
    chk("wrap_g3", 32'(out_chan), 32'd3);
    rand_data(); step();
    chk("wrap_g0", 32'(out_chan), 32'd0);
    in_valid = '0;
    step();
    chk("idle_drain", 32'(out_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rand_data();
      in_valid  = C'($urandom);
      sel       = SW'($urandom);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

`ifdef PIPE_MUX_XFER_COUNT_EN
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b1; in_valid = '1; mode = 1'b1;
    while (m_cnt != 16'hFFFF) step();
    chk("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
    step();
    chk("cnt_wrap", 32'(xfer_cnt), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
